// File: rtl/sram_1rw_bm_ctrl.sv
// sram_1rw_bm_ctrl
// Single-port (1RW) SRAM with byte write masking, a valid/ready request
// port, a fixed READ_LATENCY read pipeline and an optional zeroing sweep
// after reset.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_INIT | sweeping one zero word per cycle, requests not accepted
// S_RUN  | accepting one read or write request per cycle
//
// Ports:
//   clk0       clock, rising edge
//   rst0_n     asynchronous active-low reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wmask  byte write enables (bit i -> data bits [8i+7:8i])
//   req_wdata  write data
//   rsp_valid  one-cycle pulse per read response
//   rsp_rdata  read data, held while rsp_valid is low
//   init_done  sweep finished (always high when INIT_ZERO=0)
module sram_1rw_bm_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic                    clk0,
  input  logic                    rst0_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    init_done
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q;
  logic                    ready_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
  logic                    wr_accept;
  logic                    rd_accept;

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && init_cnt_q == '1) state_d = S_RUN;
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q    <= (INIT_ZERO != 0) ? S_INIT : S_RUN;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_RUN);
      if (state_q == S_INIT) init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
    end
  end

  // ready is registered so that it stays low throughout reset and rises on
  // the same edge that the FSM reaches S_RUN.
  assign req_ready = ready_q;
  assign init_done = (state_q == S_RUN);
  assign wr_accept = req_valid && ready_q && req_we;
  assign rd_accept = req_valid && ready_q && !req_we;

  // The array has no reset so that its contents survive rst0_n. While reset
  // is held in S_INIT the sweep repeatedly clears address 0, which the sweep
  // after release clears anyway.
  always_ff @(posedge clk0) begin
    if (state_q == S_INIT) begin
      mem[init_cnt_q] <= '0;
    end else if (wr_accept) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (req_wmask[b]) mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // Data stages only advance alongside a valid token, so the last stage
  // holds the previous response while rsp_valid is low.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_accept;
      if (rd_accept) dat_q[0] <= mem[req_addr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rsp_valid = vld_q[READ_LATENCY-1];
  assign rsp_rdata = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sram_1rw_bm_ctrl.sv
// Directed bench: three instances share one stimulus stream.
//   u_a: ADDR_WIDTH=4, READ_LATENCY=1, INIT_ZERO=1
//   u_b: ADDR_WIDTH=4, READ_LATENCY=3, INIT_ZERO=1
//   u_c: ADDR_WIDTH=4, READ_LATENCY=2, INIT_ZERO=0
module tb_sram_1rw_bm_ctrl;

  logic        clk0 = 1'b0;
  logic        rst0_n;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;

  logic        a_ready, a_vld, a_done;
  logic [31:0] a_rdata;
  logic        b_ready, b_vld, b_done;
  logic [31:0] b_rdata;
  logic        c_ready, c_vld, c_done;
  logic [31:0] c_rdata;

  int total = 0;
  int bad   = 0;
  int n;
  logic stale, early_rdy;

  always #5 clk0 = ~clk0;

  sram_1rw_bm_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .INIT_ZERO(1)) u_a (
    .clk0(clk0), .rst0_n(rst0_n), .req_valid(req_valid), .req_ready(a_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rsp_valid(a_vld), .rsp_rdata(a_rdata), .init_done(a_done));

  sram_1rw_bm_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(3), .INIT_ZERO(1)) u_b (
    .clk0(clk0), .rst0_n(rst0_n), .req_valid(req_valid), .req_ready(b_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rsp_valid(b_vld), .rsp_rdata(b_rdata), .init_done(b_done));

  sram_1rw_bm_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .INIT_ZERO(0)) u_c (
    .clk0(clk0), .rst0_n(rst0_n), .req_valid(req_valid), .req_ready(c_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rsp_valid(c_vld), .rsp_rdata(c_rdata), .init_done(c_done));

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv_wr(input logic [3:0] addr, input logic [3:0] mask, input logic [31:0] data);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wmask = mask; req_wdata = data;
  endtask

  task automatic drv_rd(input logic [3:0] addr);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_wmask = 4'h0; req_wdata = '0;
  endtask

  task automatic drv_idle();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wmask = '0; req_wdata = '0;
  endtask

  initial begin
    rst0_n = 1'b0;
    drv_idle();
    tick();
    tick();

    // reset values
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_vld",   a_vld,   0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_a_done",  a_done,  0);
    chk("rst_c_done",  c_done,  1);
    chk("rst_c_ready", c_ready, 0);

    // sweep length: init_done rises on edge 16 after release
    rst0_n = 1'b1;
    #1;
    chk("c_ready_before_edge", c_ready, 0);
    n = 0;
    early_rdy = 1'b0;
    while (!a_done && n < 40) begin
      tick();
      n++;
      if (n == 1) chk("c_ready_first_edge", c_ready, 1);
      if (!a_done) early_rdy |= a_ready;
    end
    chk("init_edges", n, 16);
    chk("ready_during_sweep", early_rdy, 0);
    chk("a_ready_after_init", a_ready, 1);
    chk("b_done_after_init", b_done, 1);

    // back-to-back reads of the whole swept array, latency 1
    for (int i = 0; i < 16; i++) begin
      drv_rd(4'(i));
      tick();
      chk($sformatf("zero_vld_%0d", i), a_vld, 1);
      chk($sformatf("zero_dat_%0d", i), a_rdata, 32'h0);
    end

    // byte masked writes
    drv_wr(4'd3, 4'hF, 32'hDEADBEEF);
    tick();
    chk("wr_no_rsp", a_vld, 0);
    drv_wr(4'd3, 4'h5, 32'h11223344);
    tick();
    drv_rd(4'd3);
    tick();
    chk("mask_a_vld", a_vld, 1);
    chk("mask_a_dat", a_rdata, 32'hDE22BE44);
    drv_idle();
    tick();
    chk("hold_a_vld", a_vld, 0);
    chk("hold_a_dat", a_rdata, 32'hDE22BE44);
    chk("mask_c_vld", c_vld, 1);
    chk("mask_c_dat", c_rdata, 32'hDE22BE44);
    tick();
    chk("mask_b_vld", b_vld, 1);
    chk("mask_b_dat", b_rdata, 32'hDE22BE44);

    // latency-3 pipeline with three back-to-back reads
    drv_wr(4'd1, 4'hF, 32'h01010101);
    tick();
    drv_wr(4'd2, 4'hF, 32'h02020202);
    tick();
    drv_rd(4'd1);
    tick();
    chk("l3_j0_vld", b_vld, 0);
    drv_rd(4'd2);
    tick();
    chk("l3_j1_vld", b_vld, 0);
    drv_rd(4'd3);
    tick();
    chk("l3_j2_vld", b_vld, 1);
    chk("l3_j2_dat", b_rdata, 32'h01010101);
    drv_idle();
    tick();
    chk("l3_j3_vld", b_vld, 1);
    chk("l3_j3_dat", b_rdata, 32'h02020202);
    tick();
    chk("l3_j4_vld", b_vld, 1);
    chk("l3_j4_dat", b_rdata, 32'hDE22BE44);
    tick();
    chk("l3_j5_vld", b_vld, 0);
    chk("l3_j5_dat", b_rdata, 32'hDE22BE44);

    // read-after-write and all-zero mask
    drv_wr(4'd7, 4'hF, 32'hA5A5A5A5);
    tick();
    drv_rd(4'd7);
    tick();
    chk("raw_dat", a_rdata, 32'hA5A5A5A5);
    drv_wr(4'd7, 4'h0, 32'h00000000);
    tick();
    drv_rd(4'd7);
    tick();
    chk("zmask_vld", a_vld, 1);
    chk("zmask_dat", a_rdata, 32'hA5A5A5A5);

    // reset with reads in flight
    drv_rd(4'd7);
    tick();
    drv_idle();
    rst0_n = 1'b0;
    #1;
    chk("mid_rst_a_vld", a_vld, 0);
    chk("mid_rst_b_vld", b_vld, 0);
    chk("mid_rst_c_vld", c_vld, 0);
    chk("mid_rst_c_dat", c_rdata, 0);
    tick();
    tick();
    rst0_n = 1'b1;
    n = 0;
    stale = 1'b0;
    early_rdy = 1'b0;
    while (!a_done && n < 40) begin
      tick();
      n++;
      if (n == 1) chk("c_ready_edge1_rerun", c_ready, 1);
      stale |= c_vld | a_vld | b_vld;
      if (!a_done) early_rdy |= a_ready;
    end
    chk("reinit_edges", n, 16);
    chk("no_stale_rsp", stale, 0);
    chk("ready_during_resweep", early_rdy, 0);

    // contents persist without a sweep, cleared with one
    drv_rd(4'd7);
    tick();
    chk("swept7_a_dat", a_rdata, 32'h0);
    drv_rd(4'd3);
    tick();
    chk("swept3_a_dat", a_rdata, 32'h0);
    chk("keep7_c_vld", c_vld, 1);
    chk("keep7_c_dat", c_rdata, 32'hA5A5A5A5);
    drv_idle();
    tick();
    chk("keep3_c_vld", c_vld, 1);
    chk("keep3_c_dat", c_rdata, 32'hDE22BE44);
    tick();
    chk("end_c_vld", c_vld, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_1rw_bm_ctrl.md
# sram_1rw_bm_ctrl

Synthesizable, parametrised single-port (1RW) SRAM block with byte-granular write masking, a valid/ready request port, a configurable fixed read latency and an optional zero-initialisation sweep after reset. It replaces the fixed-geometry 1RW SRAM behavioural models as the instruction/data memory for the RV32I core. It is the simulation and FPGA stand-in for the hard macros, with deterministic reset behaviour.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, accept-edge-to-rsp_valid latency in cycles; legal 1..4.
- INIT_ZERO, 1, 1 = clear every word after reset before accepting requests; 0 = skip the sweep.

- clk0  in  1  clock; all state updates on the rising edge.
- rst0_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wmask  in  DATA_WIDTH/8  byte write enables; bit i covers data bits [8i+7:8i].
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data valid; single-cycle pulse per read.
- rsp_rdata  out  DATA_WIDTH  read data.
- init_done  out  1  initialisation complete; stays high until the next reset.

## Operation
- FSM states: INIT and RUN.
- Reset forces the state to INIT, or to RUN if INIT_ZERO=0. Reset also clears the init counter and flushes the read pipeline.
- INIT:
  - One word is written to 0 per cycle, at addresses 0, 1, … 2**ADDR_WIDTH−1.
  - req_ready is 0 and requests are ignored.
  - After the last address is written, the FSM moves to RUN.
- RUN: req_ready is 1 every cycle. A request is accepted on any rising edge with req_valid && req_ready.
- Write accept:
  - Each byte whose req_wmask bit is 1 is updated at the accept edge; all other bytes keep their contents.
  - An all-zero mask is accepted and changes nothing.
  - A write produces no response.
- Read accept:
  - The word at req_addr is sampled at the accept edge.
  - The word then passes through a READ_LATENCY-stage valid/data pipeline.
  - Reads may be accepted back to back, one per cycle, and responses return in order.
- Read-after-write: a read accepted on the edge after a write to the same address returns the newly written data.
- Single port: exactly one operation per accept.
- No response backpressure: the consumer must take rsp_rdata while rsp_valid=1.
- rsp_rdata holds its last value while rsp_valid=0.
- Mid-operation reset:
  - In-flight reads are dropped and rsp_valid goes to 0 immediately.
  - Memory contents are not changed by the reset itself; only the INIT sweep clears them.
  - A reset during INIT restarts the sweep at address 0.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0.
  - init_done=0 when INIT_ZERO=1; init_done=1 when INIT_ZERO=0.
  - Internally, state=INIT (or RUN if INIT_ZERO=0) and the init counter is 0.
- INIT_ZERO=1 after rst0_n releases:
  - The 1st rising edge clears address 0.
  - The N-th edge clears address N−1, where N=2**ADDR_WIDTH.
  - On that same N-th edge, init_done and req_ready become 1.
  - A request is first acceptable on edge N+1.
- INIT_ZERO=0: req_ready=1 from the first cycle after reset release.
- Read accepted at edge k: rsp_valid=1 and rsp_rdata valid in the cycle following edge k+READ_LATENCY−1, i.e. rsp_valid is registered high READ_LATENCY edges after accept counting edge k itself.
- Throughput: one request per cycle, sustained.

## Test plan
- Reset with INIT_ZERO=1, ADDR_WIDTH=4 -> init_done rises exactly 16 edges after reset release; reads of addresses 0..15 all return 0x00000000.
- Write 0xDEADBEEF to address 3 with mask 0xF, then write 0x11223344 with mask 0x5, then read address 3 -> 0xDE22BE44.
- Back-to-back reads of addresses 1, 2, 3 with READ_LATENCY=3 -> rsp_valid high for 3 consecutive cycles starting 3 edges after the first accept, data in order.
- Write 0xA5A5A5A5 to address 7, then read address 7 on the next edge -> 0xA5A5A5A5; a write with mask 0x0 to address 7 -> a later read still returns 0xA5A5A5A5.
- Assert rst0_n low mid-way through a READ_LATENCY=2 read -> rsp_valid=0 immediately, no stale response after release; req_ready=0 until the sweep finishes.
- INIT_ZERO=0 -> req_ready=1 on the first edge after reset; data written before the reset is still readable after it.
